beep_driver: RTL and testbench
==============================

BEEP_DRIVER -- requirements
Module: beep_driver

Interface
REQ-001 Parameter CLK_PER_MS, default 50000, clk cycles per millisecond tick.
REQ-002 Parameter GAP_MS, default 20, length in ms of the silent gap after each note (used only with BEEP_GAP_EN).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 period  input  32  full tone period in clk cycles, as produced by the note-period table stage; 0 or 1 = rest.
REQ-006 dur_ms  input  16  note duration in ms.
REQ-007 start  input  1  one-cycle load strobe; samples period and dur_ms.
REQ-008 busy  output  1  high while a note or gap is in progress.
REQ-009 done  output  1  one-cycle pulse when the note (and gap, if enabled) completes.
REQ-010 beep  output  1  square-wave drive to the buzzer.

Function
REQ-011 The FSM SHALL have states IDLE, PLAY, GAP; busy = (state != IDLE).
REQ-012 In IDLE, start=1 SHALL latch period and dur_ms into internal registers and enter PLAY on the next edge.
REQ-013 start while busy=1 SHALL be ignored; the latched values SHALL NOT change.
REQ-014 In PLAY, a 32-bit phase counter SHALL run 0..period_q-1 and wrap to 0.
REQ-015 beep SHALL be 1 when phase < (period_q >> 1), else 0: a 50% square wave; for odd periods the high phase is floor(period_q/2) cycles.
REQ-016 period_q < 2 SHALL hold beep at 0 for the entire note (rest); duration timing is unaffected.
REQ-017 A ms tick SHALL pulse once every CLK_PER_MS cycles while busy; its prescaler SHALL restart at 0 on entry to PLAY and to GAP.
REQ-018 PLAY SHALL last exactly dur_q x CLK_PER_MS cycles; dur_q = 0 SHALL be treated as 1 ms.
REQ-019 On PLAY expiry, beep SHALL go to 0 on the same edge the state leaves PLAY.
REQ-020 done SHALL pulse for exactly one cycle, on the cycle state returns to IDLE.
REQ-021 start asserted in the same cycle as done SHALL be ignored; a new note SHALL be accepted from the following cycle.
REQ-022 beep SHALL be 0 in IDLE and GAP.

Reset
REQ-023 When rst=0 at a clock edge: state=IDLE, beep=0, busy=0, done=0, phase, prescaler, ms counter and latched registers = 0.
REQ-024 Reset mid-note SHALL abort immediately, without a done pulse.

Configuration
REQ-025 Macro BEEP_GAP_EN defined: PLAY expiry SHALL enter GAP for GAP_MS x CLK_PER_MS cycles (beep=0, busy=1), then IDLE with done.
REQ-026 BEEP_GAP_EN undefined: the GAP state and its logic SHALL be absent; PLAY expiry SHALL go directly to IDLE with done.

Structure
REQ-027 Package beep_pkg SHALL hold the state enum (IDLE, PLAY, GAP), PERIOD_W=32, DUR_W=16.
REQ-028 The ms prescaler SHALL be a sub-module beep_ms_tick (inputs clk, rst, clear, en; output tick).

Verification (CLK_PER_MS=10, GAP_MS=2)
REQ-029 period=8, dur_ms=3, start pulse -> busy next cycle; beep 4 high / 4 low repeating; PLAY exactly 30 cycles; done one cycle.
REQ-030 period=7 -> beep 3 cycles high, 4 cycles low per period.
REQ-031 period=0, dur_ms=2 -> beep stays 0; done after 20 cycles (+20 gap with BEEP_GAP_EN).
REQ-032 start with period=4 while playing period=8 -> ignored; waveform and done timing unchanged.
REQ-033 rst=0 at cycle 15 of a note -> next edge beep=0, busy=0; no done pulse.
REQ-034 With BEEP_GAP_EN: after 30 PLAY cycles, 20 cycles with beep=0 and busy=1, then done; without it, done immediately after PLAY.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared types and widths for the beep driver.
package beep_pkg;

  localparam int unsigned PERIOD_W = 32;
  localparam int unsigned DUR_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Index of the final ms tick for an n-ms interval; n = 0 behaves as 1 ms.
  function automatic logic [DUR_W-1:0] last_ms(input logic [DUR_W-1:0] n);
    return (n == '0) ? '0 : n - DUR_W'(1);
  endfunction

endpackage

// File: rtl/beep_ms_tick.sv
// Millisecond prescaler: tick pulses on the last cycle of every CLK_PER_MS-cycle window.
module beep_ms_tick #(
  parameter int unsigned CLK_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_PER_MS - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  assign tick = en && (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/beep_driver.sv
// Square-wave buzzer driver: plays one latched note for dur_ms milliseconds.
// Define BEEP_GAP_EN to append a GAP_MS silent gap after every note.
module beep_driver
  import beep_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = 50000,
  parameter int unsigned GAP_MS     = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DUR_W-1:0]    dur_ms,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                beep
);

`ifdef BEEP_GAP_EN
  localparam logic [DUR_W-1:0] GapLast = last_ms(DUR_W'(GAP_MS));
`endif

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [DUR_W-1:0]    ms_cnt_q, ms_cnt_d;
  logic                beep_q, beep_d;
  logic                done_q, done_d;
  logic                tick, tick_clear;

  beep_ms_tick #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(tick_clear),
    .en   (busy),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    dur_d      = dur_q;
    phase_d    = phase_q;
    ms_cnt_d   = ms_cnt_q;
    done_d     = 1'b0;
    tick_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The done cycle still counts as busy-adjacent: a start there is dropped.
        if (start && !done_q) begin
          period_d   = period;
          dur_d      = dur_ms;
          phase_d    = '0;
          ms_cnt_d   = '0;
          tick_clear = 1'b1;
          state_d    = PLAY;
        end
      end
      PLAY: begin
        if (period_q < PERIOD_W'(2) || phase_q >= period_q - PERIOD_W'(1)) begin
          phase_d = '0;
        end else begin
          phase_d = phase_q + PERIOD_W'(1);
        end
        if (tick) begin
          if (ms_cnt_q == last_ms(dur_q)) begin
            phase_d  = '0;
            ms_cnt_d = '0;
`ifdef BEEP_GAP_EN
            state_d    = GAP;
            tick_clear = 1'b1;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            ms_cnt_d = ms_cnt_q + DUR_W'(1);
          end
        end
      end
`ifdef BEEP_GAP_EN
      GAP: begin
        if (tick) begin
          if (ms_cnt_q == GapLast) begin
            ms_cnt_d = '0;
            state_d  = IDLE;
            done_d   = 1'b1;
          end else begin
            ms_cnt_d = ms_cnt_q + DUR_W'(1);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Registered from next-state values so beep drops on the edge PLAY ends.
    beep_d = (state_d == PLAY) && (period_d >= PERIOD_W'(2)) && (phase_d < (period_d >> 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      dur_q    <= '0;
      phase_q  <= '0;
      ms_cnt_q <= '0;
      beep_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      dur_q    <= dur_d;
      phase_q  <= phase_d;
      ms_cnt_q <= ms_cnt_d;
      beep_q   <= beep_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign beep = beep_q;

endmodule

// File: tb/tb_beep_driver.sv
// Self-checking bench for beep_driver with CLK_PER_MS=10, GAP_MS=2.
module tb_beep_driver;

  localparam int unsigned Cpm = 10;
  localparam int unsigned Gms = 2;
`ifdef BEEP_GAP_EN
  localparam int GapCycles = Gms * Cpm;
`else
  localparam int GapCycles = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] period = '0;
  logic [15:0] dur_ms = '0;
  logic        start = 1'b0;
  logic        busy, done, beep;

  int n_checks = 0;
  int n_fails  = 0;

  beep_driver #(
    .CLK_PER_MS(Cpm),
    .GAP_MS    (Gms)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .period(period),
    .dur_ms(dur_ms),
    .start (start),
    .busy  (busy),
    .done  (done),
    .beep  (beep)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: the note is a flat run of max(d,1)*Cpm cycles whose k-th cycle is high
  // when k mod p falls in the first floor(p/2) cycles, then GapCycles of silence.
  task automatic play_note(input int p, input int d, input bit poke);
    int  play_cycles;
    int  poke_at;
    logic exp_beep;
    play_cycles = ((d == 0) ? 1 : d) * Cpm;
    poke_at = poke ? int'($urandom_range(0, play_cycles + GapCycles - 1)) : -1;

    period = 32'(p);
    dur_ms = 16'(d);
    start  = 1'b1;
    step();
    start = 1'b0;

    for (int k = 0; k < play_cycles; k++) begin
      if (p >= 2) exp_beep = ((k % p) < (p / 2));
      else        exp_beep = 1'b0;
      check("busy_play", busy, 1'b1);
      check("beep_play", beep, exp_beep);
      check("done_play", done, 1'b0);
      if (k == poke_at) begin
        period = 32'd4;
        dur_ms = 16'd1;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end

    for (int g = 0; g < GapCycles; g++) begin
      check("busy_gap", busy, 1'b1);
      check("beep_gap", beep, 1'b0);
      check("done_gap", done, 1'b0);
      start = ((play_cycles + g) == poke_at);
      step();
    end
    start = 1'b0;

    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("beep_done", beep, 1'b0);

    // A start coinciding with done must not launch a note.
    period = 32'd6;
    dur_ms = 16'd1;
    start  = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_done", busy, 1'b0);
    check("done_single", done, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_beep", beep, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b1;
    step();
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);

    play_note(8, 3, 1'b1);
    play_note(7, 2, 1'b0);
    play_note(0, 2, 1'b0);
    play_note(1, 1, 1'b0);
    play_note(5, 0, 1'b0);
    play_note(2, 1, 1'b1);

    repeat (10) begin
      play_note(int'($urandom_range(0, 13)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)));
    end

    // Reset during cycle 15 of a note: abort with no done pulse.
    period = 32'd8;
    dur_ms = 16'd3;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    step();
    check("abort_beep", beep, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      check("post_abort_done", done, 1'b0);
      check("post_abort_busy", busy, 1'b0);
      step();
    end

    play_note(6, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
